// File: rtl/cpu_pkg.sv
// cpu_pkg: shared imem types; IM_ADDR_LEN/IM_DATA_LEN default to 32 when not supplied by the build.
`ifndef IM_ADDR_LEN
`define IM_ADDR_LEN 32
`endif
`ifndef IM_DATA_LEN
`define IM_DATA_LEN 32
`endif
package cpu_pkg;
  typedef enum logic [1:0] {IDLE, OUT0, OUT1} imarb_state_t;
  localparam logic [1:0] IMARB_BAD_XES  = 2'b10;
  localparam logic [1:0] IMARB_BAD_PAGE = 2'b01;
endpackage

// File: rtl/imarb_sel.sv
// imarb_sel: grant select; fixed master-1 priority with starvation override, or round-robin under IMARB_RR_EN.
module imarb_sel (
  input  logic m0_req,
  input  logic m1_req,
  output logic g
`ifdef IMARB_RR_EN
  ,
  input  logic clk,
  input  logic rstn,
  input  logic acc
`else
  ,
  input  logic starve_full
`endif
);
`ifdef IMARB_RR_EN
  logic last_q, last_d;
  // last_q resets to 1 so master 0 wins the first tie
  always_comb last_d = acc ? g : last_q;
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) last_q <= 1'b1;
    else last_q <= last_d;
  assign g = (m0_req & m1_req) ? ~last_q : m1_req;
`else
  assign g = (m0_req & m1_req) ? ~starve_full : m1_req;
`endif
endmodule

// File: rtl/imem_arb.sv
// imem_arb: two-master arbiter for a single-outstanding imem port; IMARB_RR_EN selects round-robin.
module imem_arb
  import cpu_pkg::*;
#(
  parameter int ADDR_W     = `IM_ADDR_LEN,
  parameter int DATA_W     = `IM_DATA_LEN,
  parameter int STARVE_LIM = 4
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              m0_req,
  input  logic [ADDR_W-1:0] m0_addr,
  output logic              m0_busy,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  output logic [1:0]        m0_bad,
  input  logic              m1_req,
  input  logic [ADDR_W-1:0] m1_addr,
  output logic              m1_busy,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [1:0]        m1_bad,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic [1:0]        mem_bad,
  input  logic              mem_busy
);
  logic g, acc;
  imarb_state_t state_q, state_d;
  assign mem_req  = m0_req | m1_req;
  assign mem_addr = g ? m1_addr : m0_addr;
  assign acc      = mem_req & ~mem_busy;
  assign m0_busy  = g | mem_busy;
  assign m1_busy  = ~g | mem_busy;
`ifdef IMARB_RR_EN
  imarb_sel u_sel (.m0_req(m0_req), .m1_req(m1_req), .g(g), .clk(clk), .rstn(rstn), .acc(acc));
`else
  localparam int CW = $clog2(STARVE_LIM + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  // any master-0 accept or idle master 0 forgives the starvation history
  always_comb
    cnt_d = (!m0_req || (acc && !g)) ? '0 :
            (acc && g && cnt_q != CW'(STARVE_LIM)) ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) cnt_q <= '0;
    else cnt_q <= cnt_d;
  imarb_sel u_sel (.m0_req(m0_req), .m1_req(m1_req), .g(g), .starve_full(cnt_q == CW'(STARVE_LIM)));
`endif
  always_comb
    state_d = acc ? (g ? OUT1 : OUT0) : (state_q != IDLE && !mem_busy) ? IDLE : state_q;
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) state_q <= IDLE;
    else state_q <= state_d;
  // responses follow the recorded owner, independent of the current grant
  assign m0_rvalid = (state_q == OUT0) & ~mem_busy;
  assign m1_rvalid = (state_q == OUT1) & ~mem_busy;
  assign m0_rdata  = mem_rdata;
  assign m1_rdata  = mem_rdata;
  assign m0_bad    = m0_rvalid ? mem_bad : 2'b00;
  assign m1_bad    = m1_rvalid ? mem_bad : 2'b00;
endmodule

// File: doc/imem_arb.md
# imem_arb

Two-master arbiter for the core's instruction-memory port. Shares one single-outstanding imem port between the prefetch unit (master 0) and the page-table walker / debug fetch path (master 1). Grants each cycle, tracks the owner of the outstanding transaction, and routes the response back to that owner. Sits between the IFU/PFU and the instruction-side bus bridge.

## Interface
- ADDR_W, `IM_ADDR_LEN` (32): address width
- DATA_W, `IM_DATA_LEN` (32): data width
- STARVE_LIM, 4: consecutive master-1 grants allowed while master 0 waits (fixed-priority mode only)

Ports:
- clk  in  1  clock
- rstn  in  1  reset; rstn asynchronous, active-low; clock clk
- mX_req  in  1  master X request, X∈{0,1}; held with its address until accepted
- mX_addr  in  ADDR_W  master X address
- mX_busy  out  1  master X not accepted this cycle
- mX_rvalid  out  1  master X response valid this cycle
- mX_rdata  out  DATA_W  response data, broadcast of mem_rdata
- mX_bad  out  2  response fault {xes, page}; mem_bad when mX_rvalid, else 0
- mem_req  out  1  downstream request
- mem_addr  out  ADDR_W  downstream address
- mem_rdata  in  DATA_W  downstream data
- mem_bad  in  2  downstream fault
- mem_busy  in  1  downstream stall

## Operation
- Downstream protocol: accept = mem_req & ~mem_busy. One transaction outstanding. Its response is valid in the first later cycle with mem_busy=0. A new accept may occur in that same cycle.
- FSM: IDLE, OUT0, OUT1 (owner of the outstanding transaction).
  - IDLE → OUTg on accept.
  - OUTx with mem_busy=1: stay.
  - OUTx with mem_busy=0: mX_rvalid=1. Go to OUTg if a new accept occurs, else IDLE.
- Grant select g (combinational):
  - Only one master requesting: that master.
  - Both requesting: master 1, unless starve_cnt==STARVE_LIM, then master 0.
- mem_req = m0_req | m1_req. mem_addr = mg_addr (m0_addr when neither requests).
- mX_busy = ~(g==X) | mem_busy. Master X's request is accepted when mX_req & ~mX_busy.
- starve_cnt (width $clog2(STARVE_LIM+1)):
  - Increment on a master-1 accept while m0_req=1.
  - Clear on a master-0 accept, or when m0_req=0.
  - Saturates at STARVE_LIM.
- Response routing uses the FSM owner, not g. A response to master 0 may coincide with a grant to master 1.

## Timing
- Zero-cycle grant: mem_req/mem_addr follow the requests combinationally.
- Response latency equals downstream latency. The arbiter adds no cycles.
- Reset values: FSM IDLE, starve_cnt 0, all mX_rvalid 0, mX_bad 0.
  - mem_req follows its inputs; mX_busy=1 for any non-granted master.
- Reset during an outstanding transaction: the response is dropped (no rvalid). The bridge is reset by the same rstn.
- Dropped request (mX_req low before accept): legal. No state change.
- Back-to-back: response-plus-accept in the same cycle gives 100% port utilisation.

## Configuration
- IMARB_RR_EN defined: round-robin. On contention, grant the master not granted last.
  - last_gnt flop resets to 1, so master 0 wins the first tie.
  - starve_cnt and STARVE_LIM are unused.
- Not defined: fixed master-1 priority with the starvation counter above.

## Structure
- Shared package (cpu_pkg): enum imarb_state_t {IDLE, OUT0, OUT1} and the 2-bit fault encoding constants (bit1 xes, bit0 page).
- Sub-module imarb_sel: grant-select logic, covering the priority/starvation path or the round-robin path under IMARB_RR_EN. The top module holds the FSM, counter and response routing.

## Test plan
- Only m0_req=1, addr 0x1000, mem_busy=0, single-cycle memory: m0 accepted in cycle 0; m0_rvalid=1 in cycle 1 with rdata; m1_rvalid=0 throughout.
- Both requesting continuously, STARVE_LIM=4, fixed priority: grant pattern m1,m1,m1,m1,m0 repeating; m0 is never idle longer than 4 grants.
- m0 accepted, mem_busy held high 3 cycles, m1 requesting: m1_busy=1 for those cycles. Cycle 4: m0_rvalid=1 and m1 accepted in the same cycle.
- Response carrying mem_bad=2'b10 to the master-1 transaction: m1_bad=2'b10, m0_bad=0; the owner flop is routed correctly under alternating grants.
- rstn asserted while in OUT1 with mem_busy=1: state IDLE, no m1_rvalid after release, starve_cnt=0.
- IMARB_RR_EN defined, both requesting: grants alternate m0,m1,m0,m1…, with m0 first after reset.
